// File: rtl/range_reader_pkg.sv
// Shared types and widths for the range sweep reader and the range-side logic.
// Latency: none (declarations only).
// Backpressure: not applicable.
package range_reader_pkg;

  localparam int COUNT_W = 16;
  localparam int N_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LOW,
    WAIT_DONE,
    RD_ADDR,
    RD_DATA,
    OUT
  } state_t;

endpackage

// File: rtl/range_reader_if.sv
// Bundle of the request, range-side and result-stream signals of range_reader.
// Latency: none (wiring only).
// Backpressure: carries out_valid/out_ready for the result stream.
interface range_reader_if;
  import range_reader_pkg::*;

  logic               req;
  logic [N_W-1:0]     base;
  logic               busy;
  logic               r_go;
  logic [N_W-1:0]     r_start;
  logic               r_done;
  logic [COUNT_W-1:0] r_count;
  logic               out_valid;
  logic               out_ready;
  logic [N_W-1:0]     out_n;
  logic [COUNT_W-1:0] out_count;
  logic               out_last;
  logic [COUNT_W-1:0] max_count;
  logic [N_W-1:0]     max_n;
  logic               summary_valid;

  // The reader itself.
  modport master (
    input  req, base, r_done, r_count, out_ready,
    output busy, r_go, r_start, out_valid, out_n, out_count, out_last,
           max_count, max_n, summary_valid
  );

  // Whatever surrounds the reader: host, range block and result consumer.
  modport slave (
    output req, base, r_done, r_count, out_ready,
    input  busy, r_go, r_start, out_valid, out_n, out_count, out_last,
           max_count, max_n, summary_valid
  );

endinterface

// File: rtl/range_reader.sv
// Launches a range sweep from base, waits for the RAM to fill, reads every count back and streams (n, count) beats.
// Latency: launch handshake plus range fill time, then >=3 cycles per word (address, data, beat).
// Backpressure: a beat holds all fields until out_ready; the next read is not issued while stalled.
module range_reader
  import range_reader_pkg::*;
#(
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4
) (
  input logic            clk,
  input logic            rst_n,
  range_reader_if.master bus
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                   state;
  logic [N_W-1:0]           base_q;
  logic [RAM_ADDR_BITS-1:0] idx;
  logic [RAM_ADDR_BITS-1:0] idx_nxt;
  logic [COUNT_W-1:0]       run_max;
  logic [N_W-1:0]           run_max_n;
  logic [N_W-1:0]           cur_n;

  assign idx_nxt = idx + RAM_ADDR_BITS'(1);
  // n wraps naturally at 32 bits.
  assign cur_n   = base_q + N_W'(idx);

  // Single sequencer: launch range, wait for a fresh done, then walk the RAM one beat at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      base_q            <= '0;
      idx               <= '0;
      run_max           <= '0;
      run_max_n         <= '0;
      bus.busy          <= 1'b0;
      bus.r_go          <= 1'b0;
      bus.r_start       <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_n         <= '0;
      bus.out_count     <= '0;
      bus.out_last      <= 1'b0;
      bus.max_count     <= '0;
      bus.max_n         <= '0;
      bus.summary_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            base_q            <= bus.base;
            bus.r_start       <= bus.base;
            bus.summary_valid <= 1'b0;
            run_max           <= '0;
            // Index 0 owns the max until a strictly larger count appears.
            run_max_n         <= bus.base;
            idx               <= '0;
            bus.busy          <= 1'b1;
            // r_go was low throughout IDLE, so range always sees a rising edge.
            bus.r_go          <= 1'b1;
            state             <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          // range has no reset; its done is stale until it drops in response to go.
          if (!bus.r_done) begin
            bus.r_go <= 1'b0;
            state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.r_done) begin
            bus.r_start <= N_W'(idx);
            state       <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          bus.out_count <= bus.r_count;
          bus.out_n     <= cur_n;
          bus.out_last  <= (idx == LAST_IDX);
          bus.out_valid <= 1'b1;
          // Strict compare keeps the lowest n on ties.
          if (bus.r_count > run_max) begin
            run_max   <= bus.r_count;
            run_max_n <= cur_n;
          end
          state <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.out_last) begin
              bus.max_count     <= run_max;
              bus.max_n         <= run_max_n;
              bus.summary_valid <= 1'b1;
              bus.busy          <= 1'b0;
              state             <= IDLE;
            end else begin
              idx         <= idx_nxt;
              bus.r_start <= N_W'(idx_nxt);
              state       <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_reader.sv
// Self-checking bench for range_reader with a behavioural range block holding preset counts.
// Latency: not applicable.
// Backpressure: out_ready is driven constant-high or pseudo-random per sweep.
`timescale 1ns/1ps
module tb_range_reader;
  import range_reader_pkg::*;

  localparam int WORDS = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  range_reader_if ifc ();

  range_reader #(
    .RAM_WORDS    (WORDS),
    .RAM_ADDR_BITS(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  // Behavioural range: preset RAM, registered read port, done drops on go rising and returns after a delay.
  logic [15:0] ram [WORDS];
  logic        done_m     = 1'b1;
  logic [15:0] count_m    = '0;
  logic        go_d       = 1'b0;
  int          timer      = 0;
  int          done_delay = 5;

  assign ifc.r_done  = done_m;
  assign ifc.r_count = count_m;

  // Range model sequencing.
  always @(posedge clk) begin
    go_d    <= ifc.r_go;
    count_m <= ram[ifc.r_start[3:0]];
    if (ifc.r_go && !go_d) begin
      done_m <= 1'b0;
      timer  <= done_delay;
    end else if (!done_m) begin
      if (timer == 0) done_m <= 1'b1;
      else            timer  <= timer - 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_busy"},      ifc.busy, 0);
    chk({tag, "_r_go"},      ifc.r_go, 0);
    chk({tag, "_out_valid"}, ifc.out_valid, 0);
    chk({tag, "_out_last"},  ifc.out_last, 0);
    chk({tag, "_summary"},   ifc.summary_valid, 0);
    chk({tag, "_r_start"},   ifc.r_start, 0);
    chk({tag, "_out_n"},     ifc.out_n, 0);
    chk({tag, "_out_count"}, ifc.out_count, 0);
    chk({tag, "_max_count"}, ifc.max_count, 0);
    chk({tag, "_max_n"},     ifc.max_n, 0);
  endtask

  // Called at a negedge with the reader idle.
  task automatic start(input logic [31:0] b, input bit hold);
    chk("go_low_before", ifc.r_go, 0);
    ifc.req  = 1'b1;
    ifc.base = b;
    @(negedge clk);
    chk("busy_rise", ifc.busy, 1);
    chk("summary_clear", ifc.summary_valid, 0);
    chk("go_launch", ifc.r_go, 1);
    chk("start_base", ifc.r_start, 64'(b));
    if (!hold) ifc.req = 1'b0;
  endtask

  // Consumes one sweep and checks it against a model built straight from the RAM contents.
  task automatic collect(input logic [31:0] b, input bit rand_ready);
    logic [31:0] exp_n [WORDS];
    logic [15:0] exp_c [WORDS];
    logic [15:0] mc;
    logic [31:0] mn;
    int          beats;
    int          cyc;
    bit          stalled;
    mc = '0;
    mn = b;
    for (int i = 0; i < WORDS; i++) begin
      exp_n[i] = b + 32'(i);
      exp_c[i] = ram[i];
      if (ram[i] > mc) begin
        mc = ram[i];
        mn = b + 32'(i);
      end
    end
    beats   = 0;
    cyc     = 0;
    stalled = 0;
    while (!ifc.summary_valid && cyc < 3000) begin
      if (stalled && beats < WORDS) begin
        chk("hold_valid", ifc.out_valid, 1);
        chk("hold_n",     ifc.out_n, 64'(exp_n[beats]));
        chk("hold_count", ifc.out_count, 64'(exp_c[beats]));
        chk("hold_last",  ifc.out_last, 64'(beats == WORDS - 1));
      end
      ifc.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (ifc.out_valid) begin
        if (ifc.out_ready) begin
          chk("beat_in_range", 64'(beats < WORDS), 1);
          if (beats < WORDS) begin
            chk("beat_n",     ifc.out_n, 64'(exp_n[beats]));
            chk("beat_count", ifc.out_count, 64'(exp_c[beats]));
            chk("beat_last",  ifc.out_last, 64'(beats == WORDS - 1));
          end
          beats++;
        end else begin
          stalled = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    ifc.out_ready = 1'b0;
    chk("sweep_done",     ifc.summary_valid, 1);
    chk("beat_total",     64'(beats), 64'(WORDS));
    chk("max_count",      ifc.max_count, 64'(mc));
    chk("max_n",          ifc.max_n, 64'(mn));
    chk("busy_fall",      ifc.busy, 0);
    chk("valid_fall",     ifc.out_valid, 0);
  endtask

  initial begin
    logic [15:0] table_c [WORDS];
    logic [31:0] b;
    int          cyc;

    table_c = '{16'd1, 16'd2, 16'd8, 16'd3, 16'd6, 16'd9, 16'd17, 16'd4,
                16'd20, 16'd7, 16'd15, 16'd10, 16'd10, 16'd18, 16'd18, 16'd5};
    ifc.req       = 1'b0;
    ifc.base      = '0;
    ifc.out_ready = 1'b0;

    // Power-on reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_check("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Reference table, always ready
    for (int i = 0; i < WORDS; i++) ram[i] = table_c[i];
    start(32'd1, 0);
    collect(32'd1, 0);
    chk("table_max_count", ifc.max_count, 20);
    chk("table_max_n",     ifc.max_n, 9);

    // Same table under random backpressure
    start(32'd1, 0);
    collect(32'd1, 1);

    // Tie at indices 12 and 13
    for (int i = 0; i < WORDS; i++) ram[i] = 16'($urandom_range(0, 9));
    ram[12] = 16'd10;
    ram[13] = 16'd10;
    b = $urandom;
    start(b, 0);
    collect(b, 1);
    chk("tie_max_n", ifc.max_n, 64'(b + 32'd12));

    // n wraps at 32 bits
    for (int i = 0; i < WORDS; i++) ram[i] = 16'($urandom);
    start(32'hFFFF_FFFF, 0);
    collect(32'hFFFF_FFFF, 1);

    // Reset while waiting for done
    done_delay = 100;
    b = $urandom;
    start(b, 0);
    cyc = 0;
    while (ifc.r_go && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_wait_done", ifc.r_go, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 reset_check("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_delay = $urandom_range(2, 12);
    for (int i = 0; i < WORDS; i++) ram[i] = 16'($urandom);
    b = $urandom;
    start(b, 0);
    collect(b, 1);

    // Reset while a beat is stalled
    b = $urandom;
    start(b, 0);
    cyc = 0;
    while (!ifc.out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_out", ifc.out_valid, 1);
    #1 rst_n = 1'b0;
    #1 reset_check("rst_out");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < WORDS; i++) ram[i] = 16'($urandom_range(0, 300));
    b = $urandom;
    start(b, 0);
    collect(b, 0);

    // req held high through a whole sweep: one sweep, then a fresh one once idle
    b = $urandom;
    start(b, 1);
    collect(b, 1);
    @(negedge clk);
    chk("held_req_restart", ifc.busy, 1);
    chk("held_req_summary_clear", ifc.summary_valid, 0);
    ifc.req = 1'b0;
    collect(b, 1);
    repeat (3) @(negedge clk);
    chk("idle_after_release", ifc.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
